// File: rtl/lcd_responder_pkg.sv
// Shared definitions for the HD44780-compatible responder: opcodes, address map, FSM encodings.
package lcd_responder_pkg;

  // Address map and geometry
  localparam int unsigned LINE_LEN    = 40;
  localparam int unsigned DDRAM_DEPTH = 80;
  localparam int unsigned AC_W        = 7;
  localparam int unsigned SHIFT_W     = 6;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE2_LAST = LINE2_BASE + 7'(LINE_LEN - 1);
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  // Instruction opcode: position of the highest set bit selects the command
  localparam int unsigned OP_DDRAM_BIT = 7;
  localparam int unsigned OP_CGRAM_BIT = 6;
  localparam int unsigned OP_FUNC_BIT  = 5;
  localparam int unsigned OP_SHIFT_BIT = 4;
  localparam int unsigned OP_DISP_BIT  = 3;
  localparam int unsigned OP_ENTRY_BIT = 2;
  localparam int unsigned OP_HOME_BIT  = 1;
  localparam int unsigned OP_CLEAR_BIT = 0;

  // Operand bit positions
  localparam int unsigned FS_DL_BIT = 4;
  localparam int unsigned FS_N_BIT  = 3;
  localparam int unsigned FS_F_BIT  = 2;
  localparam int unsigned SH_SC_BIT = 3;
  localparam int unsigned SH_RL_BIT = 2;
  localparam int unsigned DC_D_BIT  = 2;
  localparam int unsigned DC_C_BIT  = 1;
  localparam int unsigned DC_B_BIT  = 0;
  localparam int unsigned EM_ID_BIT = 1;
  localparam int unsigned EM_S_BIT  = 0;

  // FSM state encodings
  localparam logic [1:0] S_INIT_FILL = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_EXEC_FILL = 2'd2;
  localparam logic [1:0] S_BUSY_WAIT = 2'd3;

  // One synchronized bus sample (E travels separately for edge detection)
  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_cycle_t;

  // AC points into one of the two 40-character line windows
  function automatic logic ac_valid(input logic [6:0] ac);
    return ac[5:0] < 6'(LINE_LEN);
  endfunction

  // Linear DDRAM index for an address-counter value
  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    return ac[6] ? (7'(LINE_LEN) + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
  endfunction

  // Step AC, hopping between line windows at their ends
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == LINE1_LAST)      r = LINE2_BASE;
      else if (ac == LINE2_LAST) r = LINE1_BASE;
      else                       r = ac + 7'd1;
    end else begin
      if (ac == LINE2_BASE)      r = LINE1_LAST;
      else if (ac == LINE1_BASE) r = LINE2_LAST;
      else                       r = ac - 7'd1;
    end
    return r;
  endfunction

  // Display shift modulo the line length
  function automatic logic [5:0] shift_step(input logic [5:0] off, input logic inc);
    logic [5:0] r;
    if (inc) r = (off == 6'(LINE_LEN - 1)) ? 6'd0 : off + 6'd1;
    else     r = (off == 6'd0) ? 6'(LINE_LEN - 1) : off - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write port, synchronous read ports for the bus and the renderer.
module lcd_ddram
  import lcd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [6:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] rdata_a_q;
  logic [7:0] rdata_b_q;

  // Write port; out-of-range indices are dropped
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < 7'(DDRAM_DEPTH))) mem_q[waddr_i] <= wdata_i;
  end

  // Read ports see the pre-write contents on a same-cycle collision
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rdata_a_q <= 8'h00;
      rdata_b_q <= 8'h00;
    end else begin
      rdata_a_q <= (raddr_a_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_a_i] : BLANK_CHAR;
      rdata_b_q <= (raddr_b_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_b_i] : BLANK_CHAR;
    end
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/lcd_responder.sv
// Device side of the HD44780 parallel bus: decodes bus cycles, owns DDRAM, AC and mode flags.
module lcd_responder
  import lcd_responder_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [6:0] disp_addr,
  output logic [7:0] disp_char,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [5:0] shift_offset,
  output logic       cmd_dropped
);

  localparam int unsigned MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOME_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
  // Clear spends DDRAM_DEPTH cycles filling, the rest of CLEAR_CYCLES waiting
  localparam logic [CNT_W-1:0] CLEAR_TAIL = CNT_W'(CLEAR_CYCLES - DDRAM_DEPTH - 1);

  // Synchronizer stages
  logic       e1_q, e2_q, e3_q;
  bus_cycle_t sync1_q, sync2_q;

  // Architectural state
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         fill_q, fill_d;
  logic [AC_W-1:0]    ac_q, ac_d;
  logic               id_q, id_d, s_q, s_d;
  logic               dl_q, dl_d, n_q, n_d, f_q, f_d;
  logic               disp_on_q, disp_on_d, cur_on_q, cur_on_d, blink_q, blink_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               cg_q, cg_d;
  logic               dropped_q, dropped_d;
  logic               busy_q, busy_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_oe_q, data_oe_d;

  // Combinational controls
  logic       capture_c;
  logic [7:0] cmd_c;
  logic       go_busy;
  logic       we_c;
  logic [6:0] waddr_c;
  logic [7:0] wdata_c;
  logic [6:0] bus_raddr_c;
  logic [7:0] bus_rdata;

  assign capture_c   = e3_q & ~e2_q;
  assign cmd_c       = sync2_q.data;
  assign bus_raddr_c = ac_to_idx(ac_q);

  lcd_ddram u_ddram (
    .clk       (clk),
    .reset_i   (reset),
    .we_i      (we_c),
    .waddr_i   (waddr_c),
    .wdata_i   (wdata_c),
    .raddr_a_i (bus_raddr_c),
    .rdata_a_o (bus_rdata),
    .raddr_b_i (disp_addr),
    .rdata_b_o (disp_char)
  );

  // Two-flop synchronizer plus a third E stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      e1_q    <= 1'b0;
      e2_q    <= 1'b0;
      e3_q    <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      e1_q    <= lcd_e;
      e2_q    <= e1_q;
      e3_q    <= e2_q;
      sync1_q <= {lcd_rs, lcd_rw, data_in};
      sync2_q <= sync1_q;
    end
  end

  // Next-state: fill sequencing, busy countdown and command decode at E fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    ac_d      = ac_q;
    id_d      = id_q;
    s_d       = s_q;
    dl_d      = dl_q;
    n_d       = n_q;
    f_d       = f_q;
    disp_on_d = disp_on_q;
    cur_on_d  = cur_on_q;
    blink_d   = blink_q;
    shift_d   = shift_q;
    cg_d      = cg_q;
    dropped_d = dropped_q;
    go_busy   = 1'b0;
    we_c      = 1'b0;
    waddr_c   = fill_q;
    wdata_c   = BLANK_CHAR;

    case (state_q)
      S_INIT_FILL, S_EXEC_FILL: begin
        we_c   = 1'b1;
        fill_d = fill_q + 7'd1;
        if (fill_q == 7'(DDRAM_DEPTH - 1)) begin
          fill_d  = 7'd0;
          cnt_d   = CLEAR_TAIL;
          state_d = (state_q == S_INIT_FILL) ? S_IDLE : S_BUSY_WAIT;
        end
      end
      S_BUSY_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_IDLE: begin
        if (capture_c) begin
          if (sync2_q.rw) begin
            if (sync2_q.rs) begin
              ac_d    = ac_step(ac_q, id_q);
              go_busy = 1'b1;
            end
          end else if (sync2_q.rs) begin
            if (!cg_q) begin
              we_c    = ac_valid(ac_q);
              waddr_c = ac_to_idx(ac_q);
              wdata_c = cmd_c;
              ac_d    = ac_step(ac_q, id_q);
              if (s_q) shift_d = shift_step(shift_q, id_q);
            end
            go_busy = 1'b1;
          end else if (cmd_c[OP_DDRAM_BIT]) begin
            ac_d    = cmd_c[6:0];
            cg_d    = 1'b0;
            go_busy = 1'b1;
          end else if (cmd_c[OP_CGRAM_BIT]) begin
            cg_d    = 1'b1;
            go_busy = 1'b1;
          end else if (cmd_c[OP_FUNC_BIT]) begin
            dl_d    = cmd_c[FS_DL_BIT];
            n_d     = cmd_c[FS_N_BIT];
            f_d     = cmd_c[FS_F_BIT];
            go_busy = 1'b1;
          end else if (cmd_c[OP_SHIFT_BIT]) begin
            if (cmd_c[SH_SC_BIT]) shift_d = shift_step(shift_q, cmd_c[SH_RL_BIT]);
            else                  ac_d    = ac_step(ac_q, cmd_c[SH_RL_BIT]);
            go_busy = 1'b1;
          end else if (cmd_c[OP_DISP_BIT]) begin
            disp_on_d = cmd_c[DC_D_BIT];
            cur_on_d  = cmd_c[DC_C_BIT];
            blink_d   = cmd_c[DC_B_BIT];
            go_busy   = 1'b1;
          end else if (cmd_c[OP_ENTRY_BIT]) begin
            id_d    = cmd_c[EM_ID_BIT];
            s_d     = cmd_c[EM_S_BIT];
            go_busy = 1'b1;
          end else if (cmd_c[OP_HOME_BIT]) begin
            ac_d    = 7'h00;
            shift_d = 6'd0;
            cnt_d   = HOME_LOAD;
            state_d = S_BUSY_WAIT;
          end else if (cmd_c[OP_CLEAR_BIT]) begin
            ac_d    = 7'h00;
            id_d    = 1'b1;
            shift_d = 6'd0;
            fill_d  = 7'd0;
            state_d = S_EXEC_FILL;
          end
        end
      end
      default: state_d = S_INIT_FILL;
    endcase

    if (go_busy) begin
      state_d = S_BUSY_WAIT;
      cnt_d   = BUSY_LOAD;
    end

    if (capture_c && !sync2_q.rw && (state_q != S_IDLE)) dropped_d = 1'b1;
  end

  // Bus read response and busy flag
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    data_oe_d  = e1_q & sync1_q.rw;
    data_out_d = data_out_q;
    if (e2_q && sync2_q.rw) begin
      if (sync2_q.rs) data_out_d = ac_valid(ac_q) ? bus_rdata : BLANK_CHAR;
      else            data_out_d = {busy_q, ac_q};
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT_FILL;
      cnt_q      <= '0;
      fill_q     <= 7'd0;
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      s_q        <= 1'b0;
      dl_q       <= 1'b1;
      n_q        <= 1'b0;
      f_q        <= 1'b0;
      disp_on_q  <= 1'b0;
      cur_on_q   <= 1'b0;
      blink_q    <= 1'b0;
      shift_q    <= 6'd0;
      cg_q       <= 1'b0;
      dropped_q  <= 1'b0;
      busy_q     <= 1'b1;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      s_q        <= s_d;
      dl_q       <= dl_d;
      n_q        <= n_d;
      f_q        <= f_d;
      disp_on_q  <= disp_on_d;
      cur_on_q   <= cur_on_d;
      blink_q    <= blink_d;
      shift_q    <= shift_d;
      cg_q       <= cg_d;
      dropped_q  <= dropped_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign busy         = busy_q;
  assign display_on   = disp_on_q;
  assign cursor_on    = cur_on_q;
  assign blink_on     = blink_q;
  assign shift_offset = shift_q;
  assign cmd_dropped  = dropped_q;

endmodule
